queue_write_packer: RTL and testbench

QUEUE_WRITE_PACKER -- requirements
Module: queue_write_packer

---
 rtl/queue_write_packer.sv | 137 +++++++++++++
 tb/tb_queue_write_packer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/queue_write_packer.sv
// queue_write_packer: packs DATA_IN_WIDTH beats LSB-first into Q_DATA_WIDTH words and
// presents them to a stallable queue through a single holding register.
// Optional build macro QUEUE_WRITE_PACKER_STATS_EN adds word_count / pad_count outputs.
module queue_write_packer #(
  parameter int unsigned Q_DATA_WIDTH  = 128,
  parameter int unsigned DATA_IN_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_IN_WIDTH-1:0] in_data,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     flush_busy,
  output logic                     write_en,
  output logic [Q_DATA_WIDTH-1:0]  data_in,
  input  logic                     waitrequest
`ifdef QUEUE_WRITE_PACKER_STATS_EN
  ,
  output logic [15:0]              word_count,
  output logic [15:0]              pad_count
`endif
);

  localparam int unsigned Ratio = Q_DATA_WIDTH / DATA_IN_WIDTH;
  localparam int unsigned LaneW = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam logic [LaneW-1:0] LastLane = LaneW'(Ratio - 1);

  logic [LaneW-1:0]        lane_q, lane_d;
  logic [Q_DATA_WIDTH-1:0] asm_q, asm_d;
  logic                    hold_valid_q, hold_valid_d;
  logic [Q_DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                    flush_busy_q, flush_busy_d;

  logic                    transfer;
  logic                    hold_free;
  logic                    accept;
  logic                    flush_load;
  logic [Q_DATA_WIDTH-1:0] pad_word;

  // Handshake decode; everything is held quiet while reset is asserted.
  always_comb begin
    transfer   = rst && hold_valid_q && !waitrequest;
    hold_free  = !hold_valid_q || transfer;
    // Last lane can only be accepted if the completed word has somewhere to go.
    in_ready   = rst && !flush_busy_q && !((lane_q == LastLane) && !hold_free);
    accept     = in_valid && in_ready;
    flush_load = flush_busy_q && hold_free;
    write_en   = rst && hold_valid_q;
    data_in    = rst ? hold_data_q : '0;
    flush_busy = flush_busy_q;
  end

  // Partial word with lanes at or above lane_q forced to zero.
  always_comb begin
    pad_word = '0;
    for (int unsigned i = 0; i < Ratio; i++) begin
      if (i < 32'(lane_q)) begin
        pad_word[i*DATA_IN_WIDTH +: DATA_IN_WIDTH] = asm_q[i*DATA_IN_WIDTH +: DATA_IN_WIDTH];
      end
    end
  end

  // Next-state: beat assembly, word hand-off to holding, flush sequencing.
  always_comb begin
    lane_d       = lane_q;
    asm_d        = asm_q;
    hold_valid_d = hold_valid_q && !transfer;
    hold_data_d  = hold_data_q;
    flush_busy_d = flush_busy_q;

    if (accept) begin
      for (int unsigned i = 0; i < Ratio; i++) begin
        if (lane_q == LaneW'(i)) begin
          asm_d[i*DATA_IN_WIDTH +: DATA_IN_WIDTH] = in_data;
        end
      end
      if (lane_q == LastLane) begin
        hold_valid_d = 1'b1;
        hold_data_d  = asm_d;
        asm_d        = '0;
        lane_d       = '0;
      end else begin
        lane_d = lane_q + 1'b1;
      end
    end

    // No beat can be accepted while a flush is pending, so the two loads never collide.
    if (flush_busy_q) begin
      if (flush_load) begin
        hold_valid_d = 1'b1;
        hold_data_d  = pad_word;
        asm_d        = '0;
        lane_d       = '0;
        flush_busy_d = 1'b0;
      end
    end else if (flush && (lane_d != '0)) begin
      flush_busy_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lane_q       <= '0;
      asm_q        <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      flush_busy_q <= 1'b0;
    end else begin
      lane_q       <= lane_d;
      asm_q        <= asm_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      flush_busy_q <= flush_busy_d;
    end
  end

`ifdef QUEUE_WRITE_PACKER_STATS_EN
  logic [15:0] word_count_q, pad_count_q;

  // Free-running wrap-around counters of transfers and padded flush words.
  always_ff @(posedge clk) begin
    if (!rst) begin
      word_count_q <= '0;
      pad_count_q  <= '0;
    end else begin
      if (transfer) word_count_q <= word_count_q + 16'd1;
      if (flush_load) pad_count_q <= pad_count_q + 16'd1;
    end
  end

  assign word_count = word_count_q;
  assign pad_count  = pad_count_q;
`endif

endmodule

// File: tb/tb_queue_write_packer.sv
// Self-checking bench for queue_write_packer: directed vector table, hand-written reset
// sequence, and randomized streaming against a beat-queue reference model.
`timescale 1ns/1ps
module tb_queue_write_packer;

  localparam int unsigned QW = 128;
  localparam int unsigned DW = 64;
  localparam int unsigned R  = QW / DW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          flush = 1'b0;
  logic          waitrequest = 1'b0;
  logic          in_ready;
  logic          flush_busy;
  logic          write_en;
  logic [QW-1:0] data_in;
`ifdef QUEUE_WRITE_PACKER_STATS_EN
  logic [15:0]   word_count;
  logic [15:0]   pad_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int xfers = 0;

  logic [QW-1:0] expq[$];
  logic [DW-1:0] part[$];

  always #5 clk = ~clk;

  queue_write_packer #(.Q_DATA_WIDTH(QW), .DATA_IN_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .flush      (flush),
    .flush_busy (flush_busy),
    .write_en   (write_en),
    .data_in    (data_in),
    .waitrequest(waitrequest)
`ifdef QUEUE_WRITE_PACKER_STATS_EN
    ,
    .word_count (word_count),
    .pad_count  (pad_count)
`endif
  );

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          fl;
    logic          wr;
    logic          e_we;
    logic [QW-1:0] e_dat;
    logic          e_rdy;
    logic          e_fb;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic v, input logic [DW-1:0] d, input logic fl,
                              input logic wr, input logic e_we, input logic [QW-1:0] e_dat,
                              input logic e_rdy, input logic e_fb);
    vec_t t;
    t.v = v; t.d = d; t.fl = fl; t.wr = wr;
    t.e_we = e_we; t.e_dat = e_dat; t.e_rdy = e_rdy; t.e_fb = e_fb;
    return t;
  endfunction

  function automatic logic [QW-1:0] pack(input logic [DW-1:0] b[$]);
    logic [QW-1:0] w = '0;
    for (int i = 0; i < b.size(); i++) w[i*DW +: DW] = b[i];
    return w;
  endfunction

  task automatic chk(input string name, input logic [QW-1:0] act, input logic [QW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic we, input logic rdy, input logic fb);
    chk({name, ".write_en"}, QW'(write_en), QW'(we));
    chk({name, ".in_ready"}, QW'(in_ready), QW'(rdy));
    chk({name, ".flush_busy"}, QW'(flush_busy), QW'(fb));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One model cycle: inputs already driven; sample mid-cycle, update model, advance.
  task automatic rcycle();
    #3;
    if (write_en && !waitrequest) begin
      xfers++;
      if (expq.size() == 0) begin
        chk("spurious_write", QW'(1), QW'(0));
      end else begin
        chk("word", data_in, expq.pop_front());
      end
    end
    if (in_valid && in_ready) begin
      part.push_back(in_data);
      if (part.size() == R) begin
        expq.push_back(pack(part));
        part.delete();
      end
    end
    if (flush && !flush_busy && part.size() != 0) begin
      expq.push_back(pack(part));
      part.delete();
    end
    tick();
  endtask

  task automatic run_random(input int nbeats, input bit use_flush);
    int sent = 0;
    int cyc = 0;
    while (sent < nbeats && cyc < 20000) begin
      in_valid    = ($urandom_range(3) != 0);
      in_data     = DW'(sent);
      waitrequest = $urandom_range(1) != 0;
      flush       = use_flush && ($urandom_range(7) == 0);
      #3;
      if (in_valid && in_ready) sent++;
      #0;
      // rcycle re-samples after a further delay; values are stable within the cycle.
      rcycle_after_sample();
      cyc++;
    end
    chk("beat_budget", QW'(sent), QW'(nbeats));
    // Drain: one flush to push any partial, then let the queue empty.
    in_valid = 1'b0;
    waitrequest = 1'b0;
    flush = 1'b1;
    rcycle();
    flush = 1'b0;
    for (int i = 0; i < 20; i++) rcycle();
    chk("leftover_words", QW'(expq.size()), QW'(0));
    chk("leftover_beats", QW'(part.size()), QW'(0));
  endtask

  // Same as rcycle but the 3ns settle already elapsed in the caller.
  task automatic rcycle_after_sample();
    if (write_en && !waitrequest) begin
      xfers++;
      if (expq.size() == 0) begin
        chk("spurious_write", QW'(1), QW'(0));
      end else begin
        chk("word", data_in, expq.pop_front());
      end
    end
    if (in_valid && in_ready) begin
      part.push_back(in_data);
      if (part.size() == R) begin
        expq.push_back(pack(part));
        part.delete();
      end
    end
    if (flush && !flush_busy && part.size() != 0) begin
      expq.push_back(pack(part));
      part.delete();
    end
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    waitrequest = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    expq.delete();
    part.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [QW-1:0] w_b, w_c, w_d, w_e, w_g;
    w_b = {64'hB1, 64'hB0};
    w_c = {64'hC1, 64'hC0};
    w_d = {64'hD1, 64'hD0};
    w_e = {64'h0, 64'hE0};
    w_g = {64'h61, 64'h60};

    // Reset asserted: outputs held low.
    tick();
    #3;
    chk_out("in_reset", 1'b0, 1'b0, 1'b0);
    chk("in_reset.data_in", data_in, '0);
    tick();
    tick();
    rst = 1'b1;

    // Idle after release.
    for (int i = 0; i < 10; i++) begin
      #3;
      chk_out("idle", 1'b0, 1'b1, 1'b0);
      tick();
    end

    vt.push_back(mk(1, 64'h1111111111111111, 0, 0, 0, '0, 1, 0));
    vt.push_back(mk(1, 64'h2222222222222222, 0, 0, 0, '0, 1, 0));
    vt.push_back(mk(0, '0, 0, 0, 1, {64'h2222222222222222, 64'h1111111111111111}, 1, 0));
    vt.push_back(mk(1, 64'hAAAAAAAAAAAAAAAA, 1, 0, 0, '0, 1, 0));
    vt.push_back(mk(0, '0, 0, 0, 0, '0, 0, 1));
    vt.push_back(mk(0, '0, 0, 0, 1, {64'h0, 64'hAAAAAAAAAAAAAAAA}, 1, 0));
    vt.push_back(mk(0, '0, 1, 0, 0, '0, 1, 0));
    vt.push_back(mk(0, '0, 0, 0, 0, '0, 1, 0));
    vt.push_back(mk(0, '0, 0, 0, 0, '0, 1, 0));
    vt.push_back(mk(1, 64'hB0, 0, 1, 0, '0, 1, 0));
    vt.push_back(mk(1, 64'hB1, 0, 1, 0, '0, 1, 0));
    vt.push_back(mk(1, 64'hC0, 0, 1, 1, w_b, 1, 0));
    vt.push_back(mk(1, 64'hC1, 0, 1, 1, w_b, 0, 0));
    vt.push_back(mk(1, 64'hC1, 0, 1, 1, w_b, 0, 0));
    vt.push_back(mk(1, 64'hC1, 0, 1, 1, w_b, 0, 0));
    vt.push_back(mk(1, 64'hC1, 0, 1, 1, w_b, 0, 0));
    vt.push_back(mk(1, 64'hC1, 0, 0, 1, w_b, 1, 0));
    vt.push_back(mk(0, '0, 0, 0, 1, w_c, 1, 0));
    vt.push_back(mk(0, '0, 0, 0, 0, '0, 1, 0));
    vt.push_back(mk(1, 64'hD0, 0, 1, 0, '0, 1, 0));
    vt.push_back(mk(1, 64'hD1, 0, 1, 0, '0, 1, 0));
    vt.push_back(mk(1, 64'hE0, 1, 1, 1, w_d, 1, 0));
    vt.push_back(mk(0, '0, 1, 1, 1, w_d, 0, 1));
    vt.push_back(mk(0, '0, 0, 0, 1, w_d, 0, 1));
    vt.push_back(mk(0, '0, 0, 0, 1, w_e, 1, 0));
    vt.push_back(mk(0, '0, 0, 0, 0, '0, 1, 0));

    foreach (vt[i]) begin
      in_valid = vt[i].v;
      in_data = vt[i].d;
      flush = vt[i].fl;
      waitrequest = vt[i].wr;
      #3;
      chk_out($sformatf("vec%0d", i), vt[i].e_we, vt[i].e_rdy, vt[i].e_fb);
      if (vt[i].e_we) chk($sformatf("vec%0d.data_in", i), data_in, vt[i].e_dat);
      tick();
    end
    in_valid = 1'b0;
    flush = 1'b0;
    waitrequest = 1'b0;

    // Reset with a held word and a partial word: both discarded.
    waitrequest = 1'b1;
    in_valid = 1'b1; in_data = 64'hF0; tick();
    in_data = 64'hF1; tick();
    in_data = 64'hF2;
    #3;
    chk("rst_seq.pre_we", QW'(write_en), QW'(1));
    tick();
    in_valid = 1'b0;
    rst = 1'b0;
    #3;
    chk_out("rst_seq.during", 1'b0, 1'b0, 1'b0);
    chk("rst_seq.data_in", data_in, '0);
    tick();
    rst = 1'b1;
    waitrequest = 1'b0;
    in_valid = 1'b1; in_data = 64'h60;
    #3;
    chk_out("rst_seq.after", 1'b0, 1'b1, 1'b0);
    tick();
    in_data = 64'h61;
    #3;
    chk_out("rst_seq.lane1", 1'b0, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    #3;
    chk_out("rst_seq.word", 1'b1, 1'b1, 1'b0);
    chk("rst_seq.data_in", data_in, w_g);
    tick();
    #3;
    chk("rst_seq.single", QW'(write_en), QW'(0));
    tick();

    // 1024 incrementing beats under random stall.
    do_reset();
    xfers = 0;
    run_random(1024, 1'b0);
    chk("stream.words", QW'(xfers), QW'(512));
`ifdef QUEUE_WRITE_PACKER_STATS_EN
    chk("stream.word_count", QW'(word_count), QW'(512));
    chk("stream.pad_count", QW'(pad_count), QW'(0));
`endif

    // Random stream with random flushes.
    do_reset();
    run_random(600, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
